// File: rtl/dtree_frame_sequencer.sv
// Byte-serial feature collector and result register for the combinational arrhythmia decision tree.
// Optional frame counter output enabled by defining DTREE_FRAME_CNT_EN.
module dtree_frame_sequencer #(
  parameter int NFEAT = 5,
  parameter int FW    = 8,
  parameter int CW    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FW-1:0]       in_data,
  input  logic                in_last,
  output logic [NFEAT*FW-1:0] tree_feat,
  input  logic [CW-1:0]       tree_class,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_class,
  output logic                frame_err,
`ifdef DTREE_FRAME_CNT_EN
  output logic [15:0]         frame_cnt,
`endif
  output logic                busy
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_EVAL    = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [2:0] LAST_IDX  = 3'(NFEAT - 1);

  logic [1:0]    state_reg, state_next;
  logic [2:0]    idx_reg, idx_next;
  logic          err_reg, err_next;
  logic [CW-1:0] class_reg;
  logic          accept, at_last, good_byte, bad_byte;

  assign in_ready  = (state_reg == S_COLLECT);
  assign accept    = in_valid & in_ready;
  assign at_last   = (idx_reg == LAST_IDX);
  // A byte is well framed only when in_last coincides exactly with the final slot.
  assign good_byte = accept & (in_last == at_last);
  assign bad_byte  = accept & (in_last != at_last);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    err_next   = 1'b0;
    case (state_reg)
      S_COLLECT: begin
        if (bad_byte) begin
          idx_next = 3'd0;
          err_next = 1'b1;
        end else if (good_byte) begin
          if (at_last) begin
            idx_next   = 3'd0;
            state_next = S_EVAL;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      S_EVAL:  state_next = S_HOLD;
      S_HOLD:  if (out_ready) state_next = S_COLLECT;
      default: begin
        state_next = S_COLLECT;
        idx_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_COLLECT;
      idx_reg   <= 3'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      err_reg   <= err_next;
    end
  end

  // One holding register per feature slot; only well-framed bytes are written.
  generate
    for (genvar gi = 0; gi < NFEAT; gi++) begin : g_slot
      logic [FW-1:0] slot_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_reg <= '0;
        end else if (good_byte && (idx_reg == 3'(gi))) begin
          slot_reg <= in_data;
        end
      end
      assign tree_feat[gi*FW +: FW] = slot_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_reg <= '0;
    end else if (state_reg == S_EVAL) begin
      class_reg <= tree_class;
    end
  end

`ifdef DTREE_FRAME_CNT_EN
  logic [15:0] frame_cnt_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= 16'd0;
    end else if ((state_reg == S_HOLD) && out_ready && (frame_cnt_reg != 16'hFFFF)) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end
  assign frame_cnt = frame_cnt_reg;
`endif

  assign out_valid = (state_reg == S_HOLD);
  assign out_class = class_reg;
  assign frame_err = err_reg;
  assign busy      = !((state_reg == S_COLLECT) && (idx_reg == 3'd0));

endmodule

// File: tb/tb_dtree_frame_sequencer.sv
// Directed bench for dtree_frame_sequencer with a stub tree (class = low 5 bits of the feature vector).
// Expected classes are queued when a good frame is sent and compared when the DUT hands a class off.
module tb_dtree_frame_sequencer;
  localparam int NFEAT = 5;
  localparam int FW    = 8;
  localparam int CW    = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [FW-1:0]       in_data = '0;
  logic                in_last = 1'b0;
  logic [NFEAT*FW-1:0] tree_feat;
  logic [CW-1:0]       tree_class;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [CW-1:0]       out_class;
  logic                frame_err;
  logic                busy;
`ifdef DTREE_FRAME_CNT_EN
  logic [15:0]         frame_cnt;
`endif

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int prev_hs = -1;
  int last_hs = -1;
  logic [CW-1:0] exp_q[$];

  assign tree_class = tree_feat[4:0];

  dtree_frame_sequencer #(.NFEAT(NFEAT), .FW(FW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .tree_feat(tree_feat), .tree_class(tree_class),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .frame_err(frame_err),
`ifdef DTREE_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Output-side scoreboard: every class handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", {39'd0, out_valid}, 40'd0);
      end else begin
        logic [CW-1:0] e;
        e = exp_q.pop_front();
        check("out_class", {35'd0, out_class}, {35'd0, e});
        check("in_ready_in_hold", {39'd0, in_ready}, 40'd0);
        $display("class handshake cycle=%0d class=0x%0h expected=0x%0h", cyc, out_class, e);
      end
      prev_hs = last_hs;
      last_hs = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("byte_accept_timeout", 40'd0, 40'd1);
  endtask

  task automatic send_frame(input logic [39:0] bytes);
    for (int i = 0; i < NFEAT; i++) begin
      if (i == NFEAT - 1) exp_q.push_back(bytes[4:0]);
      send_byte(bytes[8*i +: 8], i == NFEAT - 1);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_out_valid", {39'd0, out_valid}, 40'd0);
    check("rst_out_class", {35'd0, out_class}, 40'd0);
    check("rst_tree_feat", tree_feat, 40'd0);
    check("rst_busy_err", {38'd0, busy, frame_err}, 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", {39'd0, in_ready}, 40'd1);
    check("reset_busy", {39'd0, busy}, 40'd0);
    check("reset_out_valid", {39'd0, out_valid}, 40'd0);
    check("reset_out_class", {35'd0, out_class}, 40'd0);
    check("reset_tree_feat", tree_feat, 40'd0);
    check("reset_frame_err", {39'd0, frame_err}, 40'd0);
    @(posedge clk);
    #1;

    // Basic frame: out_valid rises one cycle after the last byte.
    send_frame(40'h7864352713);
    in_valid = 1'b0;
    check("eval_out_valid_low", {39'd0, out_valid}, 40'd0);
    check("eval_in_ready_low", {39'd0, in_ready}, 40'd0);
    check("tree_feat_full", tree_feat, 40'h7864352713);
    @(posedge clk);
    #1;
    check("hold_out_valid_high", {39'd0, out_valid}, 40'd1);
    check("hold_out_class", {35'd0, out_class}, 40'h13);
    idle(2);

    // Stall: out_ready low for 10 cycles with the next byte already offered.
    out_ready = 1'b0;
    send_frame(40'h7864352713);
    in_valid = 1'b1;
    in_data  = 8'h04;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid_class_ready", {32'd0, out_valid, 2'b00, out_class, in_ready}, {32'd0, 1'b1, 2'b00, 5'h13, 1'b0});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("after_hs_not_consumed", {38'd0, in_ready, busy}, {38'd0, 1'b1, 1'b0});
    send_frame(40'h0403020104);
    idle(3);

    // Framing error: in_last on the third byte.
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    check("err1_pulse", {39'd0, frame_err}, 40'd1);
    check("err1_idx_cleared", {39'd0, busy}, 40'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("err1_pulse_end", {39'd0, frame_err}, 40'd0);
    send_frame(40'h0908070605);
    idle(3);

    // Framing error: fifth byte without in_last.
    for (int i = 0; i < NFEAT; i++) send_byte(8'h0A + 8'(i), 1'b0);
    check("err2_pulse", {39'd0, frame_err}, 40'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("err2_pulse_end", {39'd0, frame_err}, 40'd0);
    idle(10);

    // Back-to-back frames with in_valid held high.
    send_frame(40'h0504030201);
    send_frame(40'h0504030202);
    idle(4);
    check("b2b_period", 40'(last_hs - prev_hs), 40'(NFEAT + 2));

    // Reset while in HOLD.
    out_ready = 1'b0;
    send_frame(40'h1111111111);
    idle(2);
    check("pre_rst_hold", {39'd0, out_valid}, 40'd1);
    out_ready = 1'b1;
    do_reset();

    // Reset at idx 3.
    for (int i = 0; i < 3; i++) send_byte(8'h1F, 1'b0);
    in_valid = 1'b0;
    check("pre_rst_busy", {39'd0, busy}, 40'd1);
    do_reset();
    send_frame(40'h2a2b2c2d0e);
    idle(3);

`ifdef DTREE_FRAME_CNT_EN
    do_reset();
    check("cnt_reset", {24'd0, frame_cnt}, 40'd0);
    for (int i = 0; i < 3; i++) send_frame(40'h0000000007 + 40'(i));
    idle(3);
    check("cnt_three", {24'd0, frame_cnt}, 40'd3);
    force dut.frame_cnt_reg = 16'hFFFE;
    @(negedge clk);
    release dut.frame_cnt_reg;
    for (int i = 0; i < 3; i++) send_frame(40'h0000000010 + 40'(i));
    idle(3);
    check("cnt_saturate", {24'd0, frame_cnt}, 40'hFFFF);
`endif

    check("queue_drained", 40'(exp_q.size()), 40'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dtree_frame_sequencer.md
# dtree_frame_sequencer

Sequencer that feeds the combinational arrhythmia decision-tree classifier from a byte-serial feature stream. It collects one 8-bit feature per accepted beat into a holding register, presents the full vector to the tree, waits one settle cycle, and registers the class. It then offers the class on a valid/ready output. The block sits between the sensor/ADC front-end and the downstream alarm/logging logic; the tree itself stays purely combinational outside this block.

## Interface
- NFEAT, 5, features per frame; order on the stream is X13, X27, X235, X264, X278.
- FW, 8, feature width in bits.
- CW, 5, class width in bits.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  feature byte valid.
- in_ready  out  1  block accepts a byte this cycle.
- in_data  in  FW  feature byte.
- in_last  in  1  marks the final byte of a frame.
- tree_feat  out  NFEAT*FW  feature vector to the tree; slot 0 (X13) in bits [FW-1:0], slot 4 (X278) in the top byte.
- tree_class  in  CW  combinational class from the tree.
- out_valid  out  1  class available.
- out_ready  in  1  downstream accepts the class.
- out_class  out  CW  registered class.
- frame_err  out  1  one-cycle pulse when a frame is dropped for a framing error.
- busy  out  1  high in any state other than COLLECT with idx==0.

## Operation
- States: COLLECT, EVAL, HOLD.
- COLLECT:
  - in_ready=1.
  - On each handshake (in_valid&in_ready), write in_data into slot idx of the feature register.
  - When idx==NFEAT-1 and in_last=1, go to EVAL and reset idx to 0. Otherwise increment idx.
- Framing errors:
  - in_last=1 with idx<NFEAT-1: byte is discarded, idx→0, frame_err pulses, stay in COLLECT.
  - idx==NFEAT-1 with in_last=0: byte is discarded, idx→0, frame_err pulses, stay in COLLECT.
  - Feature register contents are not cleared on a framing error. Only out_class is guaranteed.
- EVAL:
  - in_ready=0, tree_feat stable.
  - At the end of the cycle, latch tree_class into out_class and go to HOLD.
- HOLD:
  - out_valid=1, in_ready=0.
  - On out_ready=1, go to COLLECT.
  - out_class holds its value until the next EVAL.
- tree_feat is always driven directly from the feature register. The tree never sees a partially written vector while in EVAL.
- idx is a 3-bit counter and never exceeds NFEAT-1.

## Timing
- Reset values:
  - State COLLECT, idx 0.
  - Feature register all zeros, so tree_feat=0.
  - out_class 0, out_valid 0, frame_err 0, busy 0.
  - in_ready 1 once rst_n is deasserted.
- Latency:
  - Last byte accepted at edge N.
  - EVAL occupies cycle N..N+1.
  - out_valid is high from edge N+1.
  - The first byte of the next frame can be accepted at the edge after the out_ready handshake. Minimum frame period is NFEAT+2 cycles.
- out_valid and out_class stay stable while out_ready=0. There is no timeout.
- in_valid while in_ready=0 is ignored: the byte is not consumed and is not counted.
- Asynchronous reset mid-frame or in HOLD returns all state to reset values immediately. A pending class is lost.
- frame_err is registered and is high for exactly the cycle after the offending byte.

## Configuration
- DTREE_FRAME_CNT_EN defined: adds output frame_cnt[15:0].
  - Increments on each HOLD→COLLECT handshake.
  - Saturates at 16'hFFFF.
  - Resets to 0.
- Not defined: no frame_cnt port and no counter logic. All other behaviour is identical.

## Test plan
- Stub tree: tree_class = tree_feat[4:0].
- Reset, then send frame 0x13,0x27,0x35,0x64,0x78 with in_last on 0x78, out_ready=1 → out_valid rises 1 cycle after the last byte. out_class=0x13, tree_feat=0x7864352713.
- Same frame with out_ready held 0 for 10 cycles → out_valid and out_class=0x13 remain stable, in_ready=0 throughout, and the first byte of the next frame is accepted only after the handshake.
- Framing errors:
  - in_last on the 3rd byte → frame_err pulse, no out_valid. A following good frame 0x05,… yields out_class=0x05.
  - 5th byte without in_last → frame_err pulse, no out_valid.
- Two back-to-back frames with out_ready=1 and in_valid always high → classes 0x01 then 0x02. Second out_valid comes exactly NFEAT+2 cycles after the first.
- rst_n asserted while in HOLD and while at idx=3 → outputs return to reset values immediately, and the next full frame is classified correctly.
- With DTREE_FRAME_CNT_EN: 3 frames → frame_cnt=3. With the counter forced to 0xFFFE, 3 more frames → frame_cnt=0xFFFF.
